// File: rtl/matmul_ctrl_if.sv
// ---------------------------------------------------------------------------
// matmul_ctrl_if
// Result writeback channel between the matmul controller and the result
// store. The controller offers one result element index per transfer and the
// store accepts it with wb_ready_i.
//
// Signals:
//   wb_valid_o  controller -> store  an element index is being offered
//   wb_ready_i  store -> controller  the store accepts the offered element
//   wb_row_o    controller -> store  row index of the offered element
//   wb_col_o    controller -> store  column index of the offered element
//
// Modports:
//   master  the controller side (drives valid/row/col)
//   slave   the result store side (drives ready)
// ---------------------------------------------------------------------------
interface matmul_ctrl_if #(
    parameter int DIM_W = 2
);
    logic             wb_valid_o;
    logic             wb_ready_i;
    logic [DIM_W-1:0] wb_row_o;
    logic [DIM_W-1:0] wb_col_o;

    modport master (
        output wb_valid_o,
        output wb_row_o,
        output wb_col_o,
        input  wb_ready_i
    );

    modport slave (
        input  wb_valid_o,
        input  wb_row_o,
        input  wb_col_o,
        output wb_ready_i
    );
endinterface

// File: rtl/matmul_ctrl.sv
// ---------------------------------------------------------------------------
// matmul_ctrl
// Sequencer for a MAX_DIM x MAX_DIM systolic matrix multiplier. One start
// request latches the operand dimensions, clears the accumulators for one
// cycle, streams skewed A/B operands into the array for a fixed number of
// steps, then walks the result elements out in row-major order over a
// valid/ready writeback channel before pulsing done.
//
// Parameters:
//   MAX_DIM  array edge size / largest supported dimension
//   DIM_W    width of the dimension fields ($clog2(MAX_DIM))
//   STEP_W   width of the feed step counter
//
// Ports:
//   clk_i           clock, everything on the rising edge
//   rst_i           synchronous active-high reset
//   start_i         start request, only looked at while idle
//   dim_n_i         rows of A minus 1
//   dim_k_i         inner dimension minus 1
//   dim_m_i         columns of B minus 1
//   busy_o          high whenever not idle
//   done_o          one-cycle completion pulse
//   acc_clr_o       one-cycle accumulator clear
//   feed_en_o       array advance enable
//   step_o          current feed step
//   a_lane_valid_o  per-row A operand valid mask
//   b_lane_valid_o  per-column B operand valid mask
//   wb              writeback channel (master side)
// ---------------------------------------------------------------------------
module matmul_ctrl #(
    parameter int MAX_DIM = 4,
    parameter int DIM_W   = 2,
    parameter int STEP_W  = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [DIM_W-1:0]    dim_n_i,
    input  logic [DIM_W-1:0]    dim_k_i,
    input  logic [DIM_W-1:0]    dim_m_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                acc_clr_o,
    output logic                feed_en_o,
    output logic [STEP_W-1:0]   step_o,
    output logic [MAX_DIM-1:0]  a_lane_valid_o,
    output logic [MAX_DIM-1:0]  b_lane_valid_o,
    matmul_ctrl_if.master       wb
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        WB    = 3'd3,
        DONE  = 3'd4
    } state_t;

    // The array needs 2*(MAX_DIM-1) extra steps beyond the k+1 useful ones so
    // the skewed operands reach the far corner of the array.
    localparam logic [STEP_W-1:0] FEED_TAIL = STEP_W'(2 * (MAX_DIM - 1));

    state_t              state_q;
    state_t              state_d;
    logic [DIM_W-1:0]    n_q;
    logic [DIM_W-1:0]    k_q;
    logic [DIM_W-1:0]    m_q;
    logic [STEP_W-1:0]   step_q;
    logic [DIM_W-1:0]    row_q;
    logic [DIM_W-1:0]    col_q;
    logic [MAX_DIM-1:0]  a_mask;
    logic [MAX_DIM-1:0]  b_mask;
    logic                feed_last;
    logic                wb_fire;
    logic                wb_last;

    assign feed_last = (step_q == (STEP_W'(k_q) + FEED_TAIL));
    assign wb_fire   = (state_q == WB) && wb.wb_ready_i;
    assign wb_last   = (row_q == n_q) && (col_q == m_q);

    // State register; reset wins over everything, including a start request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Lane i carries operand element (step - i) of its row/column, so it is
    // live only once the skew has reached it and until the k+1 inner-dimension
    // elements have passed. Lanes beyond the active dimension stay dark.
    always_comb begin
        a_mask = '0;
        b_mask = '0;
        for (int i = 0; i < MAX_DIM; i++) begin
            if ((DIM_W'(i) <= n_q) && (step_q >= STEP_W'(i)) &&
                ((step_q - STEP_W'(i)) <= STEP_W'(k_q))) begin
                a_mask[i] = 1'b1;
            end
            if ((DIM_W'(i) <= m_q) && (step_q >= STEP_W'(i)) &&
                ((step_q - STEP_W'(i)) <= STEP_W'(k_q))) begin
                b_mask[i] = 1'b1;
            end
        end
    end

    // Next-state and Moore outputs. Every output defaults to 0 so anything not
    // explicitly raised in a state reads as inactive there.
    always_comb begin
        state_d        = state_q;
        busy_o         = 1'b0;
        done_o         = 1'b0;
        acc_clr_o      = 1'b0;
        feed_en_o      = 1'b0;
        step_o         = '0;
        a_lane_valid_o = '0;
        b_lane_valid_o = '0;
        wb.wb_valid_o  = 1'b0;
        wb.wb_row_o    = '0;
        wb.wb_col_o    = '0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                busy_o    = 1'b1;
                acc_clr_o = 1'b1;
                state_d   = FEED;
            end
            FEED: begin
                busy_o         = 1'b1;
                feed_en_o      = 1'b1;
                step_o         = step_q;
                a_lane_valid_o = a_mask;
                b_lane_valid_o = b_mask;
                if (feed_last) begin
                    state_d = WB;
                end
            end
            WB: begin
                busy_o        = 1'b1;
                wb.wb_valid_o = 1'b1;
                wb.wb_row_o   = row_q;
                wb.wb_col_o   = col_q;
                if (wb.wb_ready_i && wb_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy_o  = 1'b1;
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath registers: dimensions are captured only on the accepting edge
    // so later changes on the dim inputs cannot disturb a running job. The
    // step and index counters are re-armed in CLEAR and advance only in their
    // own phase; the index pair holds while the store stalls.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            n_q    <= '0;
            k_q    <= '0;
            m_q    <= '0;
            step_q <= '0;
            row_q  <= '0;
            col_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        n_q <= dim_n_i;
                        k_q <= dim_k_i;
                        m_q <= dim_m_i;
                    end
                end
                CLEAR: begin
                    step_q <= '0;
                    row_q  <= '0;
                    col_q  <= '0;
                end
                FEED: begin
                    if (feed_last) begin
                        step_q <= '0;
                    end else begin
                        step_q <= step_q + STEP_W'(1);
                    end
                end
                WB: begin
                    if (wb_fire) begin
                        if (col_q == m_q) begin
                            col_q <= '0;
                            if (row_q == n_q) begin
                                row_q <= '0;
                            end else begin
                                row_q <= row_q + DIM_W'(1);
                            end
                        end else begin
                            col_q <= col_q + DIM_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_ctrl.sv
// ---------------------------------------------------------------------------
// tb_matmul_ctrl
// Directed bench for matmul_ctrl with the default 4x4 array. Each job is
// described by its dimensions, the number of stall cycles on the first
// writeback element, the cycle (counted from the CLEAR cycle as 0) in which
// done_o is expected, and whether stray start pulses are injected mid-job.
// Every cycle of every job is checked against the expected schedule.
// ---------------------------------------------------------------------------
module tb_matmul_ctrl;

    localparam int MAXD = 4;

    logic        clk_i;
    logic        rst_i;
    logic        start_i;
    logic [1:0]  dim_n_i;
    logic [1:0]  dim_k_i;
    logic [1:0]  dim_m_i;
    logic        busy_o;
    logic        done_o;
    logic        acc_clr_o;
    logic        feed_en_o;
    logic [3:0]  step_o;
    logic [3:0]  a_lane_valid_o;
    logic [3:0]  b_lane_valid_o;

    int totalChecks = 0;
    int badChecks   = 0;

    matmul_ctrl_if #(.DIM_W(2)) wb_bus ();

    matmul_ctrl #(
        .MAX_DIM(4),
        .DIM_W(2),
        .STEP_W(4)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .start_i(start_i),
        .dim_n_i(dim_n_i),
        .dim_k_i(dim_k_i),
        .dim_m_i(dim_m_i),
        .busy_o(busy_o),
        .done_o(done_o),
        .acc_clr_o(acc_clr_o),
        .feed_en_o(feed_en_o),
        .step_o(step_o),
        .a_lane_valid_o(a_lane_valid_o),
        .b_lane_valid_o(b_lane_valid_o),
        .wb(wb_bus)
    );

    // Free-running 10 ns clock.
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Hard stop in case the schedule ever runs away.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0d, want %0d", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Expected lane mask: lane i live when i is inside the dimension and the
    // step has passed the skew i but not beyond i+k.
    function automatic int laneMask(input int c, input int lim, input int k);
        int r;
        r = 0;
        for (int i = 0; i < MAXD; i++) begin
            if ((i <= lim) && (c >= i) && ((c - i) <= k)) begin
                r = r | (1 << i);
            end
        end
        return r;
    endfunction

    // Compares every output of the DUT against one expected cycle.
    task automatic checkCycle(input string tag, input int expBusy, input int expClr,
                              input int expFeed, input int expStep, input int expA,
                              input int expB, input int expValid, input int expRow,
                              input int expCol, input int expDone);
        checkOutput({tag, ".busy"},  int'(busy_o),            expBusy);
        checkOutput({tag, ".clr"},   int'(acc_clr_o),         expClr);
        checkOutput({tag, ".feed"},  int'(feed_en_o),         expFeed);
        checkOutput({tag, ".step"},  int'(step_o),            expStep);
        checkOutput({tag, ".amask"}, int'(a_lane_valid_o),    expA);
        checkOutput({tag, ".bmask"}, int'(b_lane_valid_o),    expB);
        checkOutput({tag, ".valid"}, int'(wb_bus.wb_valid_o), expValid);
        checkOutput({tag, ".row"},   int'(wb_bus.wb_row_o),   expRow);
        checkOutput({tag, ".col"},   int'(wb_bus.wb_col_o),   expCol);
        checkOutput({tag, ".done"},  int'(done_o),            expDone);
    endtask

    // Runs one complete job from IDLE and checks it cycle by cycle.
    // Cycle 0 is the CLEAR cycle right after the accepting edge.
    task automatic applyStimulus(input int n, input int k, input int m, input int stall,
                                 input int expDone, input bit disturb);
        int cyc;
        dim_n_i            = 2'(n);
        dim_k_i            = 2'(k);
        dim_m_i            = 2'(m);
        wb_bus.wb_ready_i  = 1'b1;
        start_i            = 1'b1;
        tick();
        start_i = 1'b0;
        dim_n_i = dim_n_i ^ 2'b11;
        dim_k_i = dim_k_i ^ 2'b10;
        dim_m_i = dim_m_i ^ 2'b01;
        cyc = 0;
        checkCycle("clear", 1, 1, 0, 0, 0, 0, 0, 0, 0, int'(cyc == expDone));

        for (int c = 0; c <= k + 2 * (MAXD - 1); c++) begin
            start_i = disturb && (c == 2);
            if (start_i) begin
                dim_n_i = 2'd3;
                dim_k_i = 2'd3;
                dim_m_i = 2'd3;
            end
            tick();
            start_i = 1'b0;
            cyc++;
            checkCycle("feed", 1, 0, 1, c, laneMask(c, n, k), laneMask(c, m, k),
                       0, 0, 0, int'(cyc == expDone));
        end

        wb_bus.wb_ready_i = (stall == 0);
        for (int r = 0; r <= n; r++) begin
            for (int cl = 0; cl <= m; cl++) begin
                start_i = disturb && (r == 0) && (cl == 1);
                tick();
                start_i = 1'b0;
                cyc++;
                checkCycle("wb", 1, 0, 0, 0, 0, 0, 1, r, cl, int'(cyc == expDone));
                if ((r == 0) && (cl == 0) && (stall > 0)) begin
                    for (int s = 1; s <= stall; s++) begin
                        tick();
                        cyc++;
                        checkCycle("stall", 1, 0, 0, 0, 0, 0, 1, 0, 0, int'(cyc == expDone));
                        if (s == stall) begin
                            wb_bus.wb_ready_i = 1'b1;
                        end
                    end
                end
            end
        end

        tick();
        cyc++;
        checkCycle("done", 1, 0, 0, 0, 0, 0, 0, 0, 0, int'(cyc == expDone));
        tick();
        checkCycle("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Directed job table. Done cycle = k + 8 + (n+1)(m+1) + stall cycles,
    // counted from the CLEAR cycle.
    initial begin
        rst_i             = 1'b1;
        start_i           = 1'b0;
        dim_n_i           = '0;
        dim_k_i           = '0;
        dim_m_i           = '0;
        wb_bus.wb_ready_i = 1'b1;
        tick();
        tick();
        checkCycle("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_i = 1'b0;
        tick();
        checkCycle("postreset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] job 0/0/0");
        applyStimulus(0, 0, 0, 0, 9, 1'b0);
        $display("[TB] job 3/3/3");
        applyStimulus(3, 3, 3, 0, 27, 1'b0);
        $display("[TB] job 1/2/0 no stall");
        applyStimulus(1, 2, 0, 0, 12, 1'b0);
        $display("[TB] job 1/2/0 with 5-cycle stall");
        applyStimulus(1, 2, 0, 5, 17, 1'b0);
        $display("[TB] job 2/1/3 with stray starts");
        applyStimulus(2, 1, 3, 0, 21, 1'b1);
        $display("[TB] job 0/3/2");
        applyStimulus(0, 3, 2, 0, 14, 1'b0);

        $display("[TB] reset during FEED");
        dim_n_i = 2'd3;
        dim_k_i = 2'd3;
        dim_m_i = 2'd3;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        tick();
        checkOutput("midfeed.step", int'(step_o), 1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        checkCycle("rstfeed", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checkCycle("rstfeed.idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 2, 0, 15, 1'b0);

        $display("[TB] reset and start together");
        dim_n_i = 2'd2;
        dim_k_i = 2'd2;
        dim_m_i = 2'd2;
        rst_i   = 1'b1;
        start_i = 1'b1;
        tick();
        rst_i   = 1'b0;
        start_i = 1'b0;
        checkCycle("rststart", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checkCycle("rststart.idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 10, 1'b0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
